// File: rtl/cajero_transaccion_if.sv
// Bus between the cashier transaction stage and its environment.
// The master side drives the requests; the slave side is the transaction stage.
interface cajero_transaccion_if #(
   parameter int unsigned BAL_W = 32
);
   logic             pin_valido;
   logic [BAL_W-1:0] balance_inicial;
   logic             tipo_trans;
   logic             monto_stb;
   logic [BAL_W-1:0] monto;
   logic             ocupado;
   logic [BAL_W-1:0] balance_actualizado;
   logic             balance_stb;
   logic             entregar_dinero;
   logic             fondos_insuficientes;
   logic             desborde;
   logic             limite_excedido;
   logic             tiempo_agotado;
   logic             transaccion_fin;

   modport master (
      output pin_valido, balance_inicial, tipo_trans, monto_stb, monto,
      input  ocupado, balance_actualizado, balance_stb, entregar_dinero,
             fondos_insuficientes, desborde, limite_excedido, tiempo_agotado,
             transaccion_fin
   );

   modport slave (
      input  pin_valido, balance_inicial, tipo_trans, monto_stb, monto,
      output ocupado, balance_actualizado, balance_stb, entregar_dinero,
             fondos_insuficientes, desborde, limite_excedido, tiempo_agotado,
             transaccion_fin
   );
endinterface

// File: rtl/cajero_transaccion.sv
// Cashier transaction stage: one deposit or withdrawal per accepted PIN.
// Optional per-session withdrawal limit enabled by defining CAJERO_LIMITE_RETIRO_EN.
module cajero_transaccion #(
   parameter int unsigned BAL_W          = 32,
   parameter int unsigned ENTREGA_CICLOS = 4,
   parameter int unsigned TIMEOUT_CICLOS = 1000
`ifdef CAJERO_LIMITE_RETIRO_EN
   ,
   parameter int unsigned LIMITE_RETIRO  = 50000
`endif
) (
   input logic              i_clock,
   input logic              i_reset,
   cajero_transaccion_if.slave bus
);

   localparam int unsigned CNT_MAX = (TIMEOUT_CICLOS > ENTREGA_CICLOS) ? TIMEOUT_CICLOS
                                                                       : ENTREGA_CICLOS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      ESPERA,
      ESPERA_MONTO,
      EJECUTA,
      ENTREGA,
      FIN
   } estado_t;

   estado_t          r_estado, w_estado_sig;
   logic [BAL_W-1:0] r_balance, w_balance_sig;
   logic [BAL_W-1:0] r_monto, w_monto_sig;
   logic             r_tipo, w_tipo_sig;
   logic [CNT_W-1:0] r_cnt, w_cnt_sig;
   logic [BAL_W-1:0] r_bal_act, w_bal_act_sig;
   logic             r_ocupado, w_ocupado_sig;
   logic             r_stb, w_stb_sig;
   logic             r_entregar, w_entregar_sig;
   logic             r_fondos, w_fondos_sig;
   logic             r_desborde, w_desborde_sig;
   logic             r_tiempo, w_tiempo_sig;
   logic             r_fin, w_fin_sig;
   logic [BAL_W:0]   w_suma;
`ifdef CAJERO_LIMITE_RETIRO_EN
   logic             r_limite, w_limite_sig;
`endif

   assign w_suma = {1'b0, r_balance} + {1'b0, r_monto};

   // State register and registered outputs
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_estado   <= ESPERA;
         r_balance  <= '0;
         r_monto    <= '0;
         r_tipo     <= 1'b0;
         r_cnt      <= '0;
         r_bal_act  <= '0;
         r_ocupado  <= 1'b0;
         r_stb      <= 1'b0;
         r_entregar <= 1'b0;
         r_fondos   <= 1'b0;
         r_desborde <= 1'b0;
         r_tiempo   <= 1'b0;
         r_fin      <= 1'b0;
`ifdef CAJERO_LIMITE_RETIRO_EN
         r_limite   <= 1'b0;
`endif
      end else begin
         r_estado   <= w_estado_sig;
         r_balance  <= w_balance_sig;
         r_monto    <= w_monto_sig;
         r_tipo     <= w_tipo_sig;
         r_cnt      <= w_cnt_sig;
         r_bal_act  <= w_bal_act_sig;
         r_ocupado  <= w_ocupado_sig;
         r_stb      <= w_stb_sig;
         r_entregar <= w_entregar_sig;
         r_fondos   <= w_fondos_sig;
         r_desborde <= w_desborde_sig;
         r_tiempo   <= w_tiempo_sig;
         r_fin      <= w_fin_sig;
`ifdef CAJERO_LIMITE_RETIRO_EN
         r_limite   <= w_limite_sig;
`endif
      end
   end

   // Next state and the values the output registers take on the coming edge
   always_comb begin
      w_estado_sig   = r_estado;
      w_balance_sig  = r_balance;
      w_monto_sig    = r_monto;
      w_tipo_sig     = r_tipo;
      w_cnt_sig      = r_cnt;
      w_bal_act_sig  = r_bal_act;
      w_stb_sig      = 1'b0;
      w_entregar_sig = 1'b0;
      w_fondos_sig   = 1'b0;
      w_desborde_sig = 1'b0;
      w_tiempo_sig   = 1'b0;
`ifdef CAJERO_LIMITE_RETIRO_EN
      w_limite_sig   = 1'b0;
`endif

      case (r_estado)
         ESPERA: begin
            if (bus.pin_valido) begin
               w_balance_sig = bus.balance_inicial;
               w_cnt_sig     = '0;
               w_estado_sig  = ESPERA_MONTO;
            end
         end
         ESPERA_MONTO: begin
            // A strobe on the final timeout cycle still wins over the timeout
            if (bus.monto_stb) begin
               w_monto_sig  = bus.monto;
               w_tipo_sig   = bus.tipo_trans;
               w_estado_sig = EJECUTA;
            end else if (r_cnt == CNT_W'(TIMEOUT_CICLOS - 1)) begin
               w_tiempo_sig = 1'b1;
               w_estado_sig = FIN;
            end else begin
               w_cnt_sig = r_cnt + CNT_W'(1);
            end
         end
         EJECUTA: begin
            w_cnt_sig    = '0;
            w_estado_sig = FIN;
            if (!r_tipo) begin
               if (w_suma[BAL_W]) begin
                  w_desborde_sig = 1'b1;
               end else begin
                  w_balance_sig = w_suma[BAL_W-1:0];
                  w_bal_act_sig = w_suma[BAL_W-1:0];
                  w_stb_sig     = 1'b1;
               end
            end
`ifdef CAJERO_LIMITE_RETIRO_EN
            else if (r_monto > BAL_W'(LIMITE_RETIRO)) begin
               w_limite_sig = 1'b1;
            end
`endif
            else if (r_monto > r_balance) begin
               w_fondos_sig = 1'b1;
            end else begin
               w_balance_sig = r_balance - r_monto;
               w_bal_act_sig = r_balance - r_monto;
               w_stb_sig     = 1'b1;
               if (r_monto != '0) begin
                  w_entregar_sig = 1'b1;
                  w_estado_sig   = ENTREGA;
               end
            end
         end
         ENTREGA: begin
            // First dispense cycle was raised by EJECUTA; count the remaining ones
            if (r_cnt == CNT_W'(ENTREGA_CICLOS - 1)) begin
               w_estado_sig = FIN;
            end else begin
               w_cnt_sig      = r_cnt + CNT_W'(1);
               w_entregar_sig = 1'b1;
            end
         end
         FIN: begin
            w_estado_sig = ESPERA;
         end
         default: begin
            w_estado_sig = ESPERA;
         end
      endcase

      w_fin_sig     = (w_estado_sig == FIN);
      w_ocupado_sig = (w_estado_sig != ESPERA);
   end

   assign bus.ocupado              = r_ocupado;
   assign bus.balance_actualizado  = r_bal_act;
   assign bus.balance_stb          = r_stb;
   assign bus.entregar_dinero      = r_entregar;
   assign bus.fondos_insuficientes = r_fondos;
   assign bus.desborde             = r_desborde;
   assign bus.tiempo_agotado       = r_tiempo;
   assign bus.transaccion_fin      = r_fin;
`ifdef CAJERO_LIMITE_RETIRO_EN
   assign bus.limite_excedido      = r_limite;
`else
   assign bus.limite_excedido      = 1'b0;
`endif

endmodule

// File: tb/tb_cajero_transaccion.sv
// Directed self-checking bench for cajero_transaccion (default parameters; limit of 500
// when CAJERO_LIMITE_RETIRO_EN is defined).
module tb_cajero_transaccion;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_err = 0;
   int   n_chk = 0;

   int cnt_stb, cnt_ent, cnt_fondos, cnt_desb, cnt_lim, cnt_tiempo, cnt_fin;
   int cyc_stb, cyc_ent_first, cyc_ent_last, cyc_tiempo, cyc_fin, cyc_err;

   cajero_transaccion_if #(.BAL_W(32)) bus ();

   always #5 clk = ~clk;

`ifdef CAJERO_LIMITE_RETIRO_EN
   cajero_transaccion #(.BAL_W(32), .ENTREGA_CICLOS(4), .TIMEOUT_CICLOS(1000),
                        .LIMITE_RETIRO(500)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );
`else
   cajero_transaccion #(.BAL_W(32), .ENTREGA_CICLOS(4), .TIMEOUT_CICLOS(1000)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs ncyc cycles, recording how often and when each output pulses (cycle 1 = next edge)
   task automatic observe(input int ncyc);
      cnt_stb = 0; cnt_ent = 0; cnt_fondos = 0; cnt_desb = 0; cnt_lim = 0;
      cnt_tiempo = 0; cnt_fin = 0;
      cyc_stb = -1; cyc_ent_first = -1; cyc_ent_last = -1; cyc_tiempo = -1;
      cyc_fin = -1; cyc_err = -1;
      for (int c = 1; c <= ncyc; c++) begin
         tick();
         if (bus.balance_stb) begin cnt_stb++; cyc_stb = c; end
         if (bus.entregar_dinero) begin
            cnt_ent++;
            if (cyc_ent_first < 0) cyc_ent_first = c;
            cyc_ent_last = c;
         end
         if (bus.fondos_insuficientes) begin cnt_fondos++; cyc_err = c; end
         if (bus.desborde) begin cnt_desb++; cyc_err = c; end
         if (bus.limite_excedido) begin cnt_lim++; cyc_err = c; end
         if (bus.tiempo_agotado) begin cnt_tiempo++; cyc_tiempo = c; end
         if (bus.transaccion_fin) begin cnt_fin++; cyc_fin = c; end
      end
   endtask

   task automatic pin_pulse(input logic [31:0] bal);
      bus.pin_valido = 1'b1;
      bus.balance_inicial = bal;
      tick();
      bus.pin_valido = 1'b0;
   endtask

   task automatic monto_pulse(input logic tipo, input logic [31:0] amt);
      bus.monto_stb = 1'b1;
      bus.tipo_trans = tipo;
      bus.monto = amt;
      tick();
      bus.monto_stb = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_chk++; if (bus.ocupado !== 1'b0) begin n_err++; $display("FAIL rst_ocupado: got %b want 0", bus.ocupado); end
      n_chk++; if (bus.balance_actualizado !== 32'd0) begin n_err++; $display("FAIL rst_balance: got %0d want 0", bus.balance_actualizado); end
      n_chk++; if ({bus.balance_stb, bus.entregar_dinero, bus.fondos_insuficientes, bus.desborde,
                    bus.limite_excedido, bus.tiempo_agotado, bus.transaccion_fin} !== 7'b0) begin
         n_err++; $display("FAIL rst_pulses: got %b want 0000000", {bus.balance_stb, bus.entregar_dinero,
            bus.fondos_insuficientes, bus.desborde, bus.limite_excedido, bus.tiempo_agotado, bus.transaccion_fin});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_deposit();
      pin_pulse(32'd1000);
      n_chk++; if (bus.ocupado !== 1'b1) begin n_err++; $display("FAIL dep_ocupado: got %b want 1", bus.ocupado); end
      monto_pulse(1'b0, 32'd250);
      n_chk++; if (bus.balance_stb !== 1'b0) begin n_err++; $display("FAIL dep_early_stb: got %b want 0", bus.balance_stb); end
      observe(6);
      n_chk++; if (bus.balance_actualizado !== 32'd1250) begin n_err++; $display("FAIL dep_balance: got %0d want 1250", bus.balance_actualizado); end
      n_chk++; if (cnt_stb !== 1 || cyc_stb !== 1) begin n_err++; $display("FAIL dep_stb: got count %0d at %0d want 1 at 1", cnt_stb, cyc_stb); end
      n_chk++; if (cnt_ent !== 0) begin n_err++; $display("FAIL dep_dispense: got %0d want 0", cnt_ent); end
      n_chk++; if (cnt_fin !== 1 || cyc_fin !== 1) begin n_err++; $display("FAIL dep_fin: got count %0d at %0d want 1 at 1", cnt_fin, cyc_fin); end
      n_chk++; if (bus.ocupado !== 1'b0) begin n_err++; $display("FAIL dep_idle: got %b want 0", bus.ocupado); end
   endtask

   task automatic test_withdraw_all();
      pin_pulse(32'd1000);
      monto_pulse(1'b1, 32'd1000);
      observe(8);
      n_chk++; if (bus.balance_actualizado !== 32'd0) begin n_err++; $display("FAIL wd_balance: got %0d want 0", bus.balance_actualizado); end
      n_chk++; if (cnt_stb !== 1 || cyc_stb !== 1) begin n_err++; $display("FAIL wd_stb: got count %0d at %0d want 1 at 1", cnt_stb, cyc_stb); end
      n_chk++; if (cnt_ent !== 4 || cyc_ent_first !== 1 || cyc_ent_last !== 4) begin
         n_err++; $display("FAIL wd_dispense: got %0d cycles %0d..%0d want 4 cycles 1..4", cnt_ent, cyc_ent_first, cyc_ent_last);
      end
      n_chk++; if (cnt_fin !== 1 || cyc_fin !== 5) begin n_err++; $display("FAIL wd_fin: got count %0d at %0d want 1 at 5", cnt_fin, cyc_fin); end
   endtask

   task automatic test_insufficient();
      pin_pulse(32'd100);
      monto_pulse(1'b1, 32'd101);
      observe(6);
      n_chk++; if (cnt_fondos !== 1 || cyc_err !== 1) begin n_err++; $display("FAIL nsf_pulse: got count %0d at %0d want 1 at 1", cnt_fondos, cyc_err); end
      n_chk++; if (bus.balance_actualizado !== 32'd0) begin n_err++; $display("FAIL nsf_balance: got %0d want 0", bus.balance_actualizado); end
      n_chk++; if (cnt_stb !== 0 || cnt_ent !== 0) begin n_err++; $display("FAIL nsf_side: got stb %0d ent %0d want 0 0", cnt_stb, cnt_ent); end
      n_chk++; if (cnt_fin !== 1 || cyc_fin !== 1) begin n_err++; $display("FAIL nsf_fin: got count %0d at %0d want 1 at 1", cnt_fin, cyc_fin); end
   endtask

   task automatic test_overflow_timeout();
      pin_pulse(32'hFFFF_FFF0);
      monto_pulse(1'b0, 32'h20);
      observe(5);
      n_chk++; if (cnt_desb !== 1 || cyc_err !== 1) begin n_err++; $display("FAIL ovf_pulse: got count %0d at %0d want 1 at 1", cnt_desb, cyc_err); end
      n_chk++; if (cnt_stb !== 0) begin n_err++; $display("FAIL ovf_stb: got %0d want 0", cnt_stb); end
      n_chk++; if (bus.balance_actualizado !== 32'd0) begin n_err++; $display("FAIL ovf_balance: got %0d want 0", bus.balance_actualizado); end
      // Largest sum that still fits
      pin_pulse(32'hFFFF_FFF0);
      monto_pulse(1'b0, 32'h0F);
      observe(4);
      n_chk++; if (cnt_desb !== 0 || bus.balance_actualizado !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL max_sum: got desborde %0d balance %h want 0 ffffffff", cnt_desb, bus.balance_actualizado);
      end
      pin_pulse(32'd10);
      observe(1010);
      n_chk++; if (cnt_tiempo !== 1 || cyc_tiempo !== 1000) begin n_err++; $display("FAIL to_pulse: got count %0d at %0d want 1 at 1000", cnt_tiempo, cyc_tiempo); end
      n_chk++; if (cnt_fin !== 1 || cyc_fin !== 1000) begin n_err++; $display("FAIL to_fin: got count %0d at %0d want 1 at 1000", cnt_fin, cyc_fin); end
      n_chk++; if (cnt_stb !== 0 || bus.ocupado !== 1'b0) begin n_err++; $display("FAIL to_side: got stb %0d ocupado %b want 0 0", cnt_stb, bus.ocupado); end
   endtask

   task automatic test_ignored();
      bus.monto_stb = 1'b1; bus.tipo_trans = 1'b0; bus.monto = 32'd7;
      tick();
      bus.monto_stb = 1'b0;
      observe(4);
      n_chk++; if (cnt_stb !== 0 || bus.ocupado !== 1'b0) begin n_err++; $display("FAIL idle_stb: got stb %0d ocupado %b want 0 0", cnt_stb, bus.ocupado); end
      pin_pulse(32'd1000);
      pin_pulse(32'd5);
      monto_pulse(1'b0, 32'd1);
      observe(4);
      n_chk++; if (bus.balance_actualizado !== 32'd1001 || cyc_stb !== 1) begin
         n_err++; $display("FAIL second_pin: got %0d at %0d want 1001 at 1", bus.balance_actualizado, cyc_stb);
      end
      pin_pulse(32'd77);
      monto_pulse(1'b1, 32'd0);
      observe(4);
      n_chk++; if (cnt_stb !== 1 || cnt_ent !== 0 || bus.balance_actualizado !== 32'd77) begin
         n_err++; $display("FAIL zero_wd: got stb %0d ent %0d bal %0d want 1 0 77", cnt_stb, cnt_ent, bus.balance_actualizado);
      end
   endtask

   task automatic test_reset_mid_dispense();
      pin_pulse(32'd500);
      monto_pulse(1'b1, 32'd200);
      tick();
      n_chk++; if (bus.entregar_dinero !== 1'b1 || bus.balance_actualizado !== 32'd300) begin
         n_err++; $display("FAIL mid_first: got ent %b bal %0d want 1 300", bus.entregar_dinero, bus.balance_actualizado);
      end
      bus.pin_valido = 1'b1; bus.balance_inicial = 32'd9999;
      bus.monto_stb = 1'b1; bus.tipo_trans = 1'b0; bus.monto = 32'd5;
      tick();
      bus.pin_valido = 1'b0; bus.monto_stb = 1'b0;
      n_chk++; if (bus.entregar_dinero !== 1'b1 || bus.balance_stb !== 1'b0) begin
         n_err++; $display("FAIL mid_second: got ent %b stb %b want 1 0", bus.entregar_dinero, bus.balance_stb);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++; if ({bus.ocupado, bus.entregar_dinero, bus.transaccion_fin, bus.balance_stb} !== 4'b0 ||
                   bus.balance_actualizado !== 32'd0) begin
         n_err++; $display("FAIL mid_reset: got oc/ent/fin/stb %b bal %0d want 0000 0",
            {bus.ocupado, bus.entregar_dinero, bus.transaccion_fin, bus.balance_stb}, bus.balance_actualizado);
      end
      observe(10);
      n_chk++; if (cnt_fin !== 0 || cnt_ent !== 0 || cnt_stb !== 0 || bus.ocupado !== 1'b0) begin
         n_err++; $display("FAIL mid_after: got fin %0d ent %0d stb %0d oc %b want 0 0 0 0", cnt_fin, cnt_ent, cnt_stb, bus.ocupado);
      end
   endtask

   task automatic test_limit();
      pin_pulse(32'd1000);
      monto_pulse(1'b1, 32'd600);
      observe(8);
`ifdef CAJERO_LIMITE_RETIRO_EN
      n_chk++; if (cnt_lim !== 1 || cyc_err !== 1 || cnt_fondos !== 0) begin
         n_err++; $display("FAIL lim_pulse: got lim %0d at %0d nsf %0d want 1 at 1 0", cnt_lim, cyc_err, cnt_fondos);
      end
      n_chk++; if (cnt_stb !== 0 || cnt_ent !== 0 || bus.balance_actualizado !== 32'd0) begin
         n_err++; $display("FAIL lim_side: got stb %0d ent %0d bal %0d want 0 0 0", cnt_stb, cnt_ent, bus.balance_actualizado);
      end
      pin_pulse(32'd100);
      monto_pulse(1'b1, 32'd700);
      observe(4);
      n_chk++; if (cnt_lim !== 1 || cnt_fondos !== 0) begin n_err++; $display("FAIL lim_prio: got lim %0d nsf %0d want 1 0", cnt_lim, cnt_fondos); end
`else
      n_chk++; if (cnt_lim !== 0 || bus.balance_actualizado !== 32'd400) begin
         n_err++; $display("FAIL nolim_balance: got lim %0d bal %0d want 0 400", cnt_lim, bus.balance_actualizado);
      end
      n_chk++; if (cnt_ent !== 4 || cyc_fin !== 5) begin n_err++; $display("FAIL nolim_dispense: got ent %0d fin at %0d want 4 at 5", cnt_ent, cyc_fin); end
`endif
   endtask

   initial begin
      bus.pin_valido = 1'b0;
      bus.balance_inicial = '0;
      bus.tipo_trans = 1'b0;
      bus.monto_stb = 1'b0;
      bus.monto = '0;
      test_reset();
      test_deposit();
      test_withdraw_all();
      test_insufficient();
      test_overflow_timeout();
      test_ignored();
      test_reset_mid_dispense();
      test_limit();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
